// File: rtl/io_generic_fifo_pro.sv
// Synchronous valid/ready FIFO with arbitrary depth, optional fall-through bypass,
// programmable almost-full/almost-empty flags, free-slot count and sticky overflow.
module io_generic_fifo_pro #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned BUFFER_DEPTH     = 4,
  parameter bit          FALL_THROUGH     = 1'b0,
  parameter int unsigned LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        clr_i,
  input  logic [LOG_BUFFER_DEPTH:0]   af_thresh_i,
  input  logic [LOG_BUFFER_DEPTH:0]   ae_thresh_i,
  input  logic                        valid_i,
  input  logic [DATA_WIDTH-1:0]       data_i,
  output logic                        ready_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [LOG_BUFFER_DEPTH:0]   elements_o,
  output logic [LOG_BUFFER_DEPTH:0]   free_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic                        almost_full_o,
  output logic                        almost_empty_o,
  output logic                        overflow_o
);

  localparam int unsigned CW = LOG_BUFFER_DEPTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUFFER_DEPTH);
  localparam logic [LOG_BUFFER_DEPTH-1:0] LAST_C = LOG_BUFFER_DEPTH'(BUFFER_DEPTH - 1);

  logic [DATA_WIDTH-1:0]       r_buffer [BUFFER_DEPTH];
  logic [LOG_BUFFER_DEPTH-1:0] r_wr_ptr;
  logic [LOG_BUFFER_DEPTH-1:0] r_rd_ptr;
  logic [CW-1:0]               r_elements;
  logic                        r_overflow;

  logic                        w_full;
  logic                        w_empty;
  logic                        w_bypass;
  logic                        w_push;
  logic                        w_pop;
  logic [LOG_BUFFER_DEPTH-1:0] w_wr_ptr_inc;
  logic [LOG_BUFFER_DEPTH-1:0] w_rd_ptr_inc;

  assign w_full  = (r_elements == DEPTH_C);
  assign w_empty = (r_elements == '0);

  // In fall-through mode an empty FIFO hands the word straight to a ready sink.
  assign w_bypass = FALL_THROUGH && w_empty && valid_i && ready_i;
  assign w_push   = valid_i && !w_full && !w_bypass;
  assign w_pop    = !w_empty && ready_i;

  // Explicit wrap keeps non-power-of-two depths inside the buffer.
  assign w_wr_ptr_inc = (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_inc = (r_rd_ptr == LAST_C) ? '0 : r_rd_ptr + 1'b1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_elements <= '0;
      r_overflow <= 1'b0;
    end else if (clr_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_elements <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_ptr_inc;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      if (w_push && !w_pop)      r_elements <= r_elements + 1'b1;
      else if (!w_push && w_pop) r_elements <= r_elements - 1'b1;
      if (valid_i && w_full) r_overflow <= 1'b1;
    end
  end

  // Clear leaves the stored words in place; they become unreachable via the pointers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(BUFFER_DEPTH); i++) r_buffer[i] <= '0;
    end else if (!clr_i && w_push) begin
      r_buffer[r_wr_ptr] <= data_i;
    end
  end

  assign ready_o        = !w_full;
  assign valid_o        = FALL_THROUGH ? (!w_empty || valid_i) : !w_empty;
  assign data_o         = (FALL_THROUGH && w_empty) ? data_i : r_buffer[r_rd_ptr];
  assign elements_o     = r_elements;
  assign free_o         = DEPTH_C - r_elements;
  assign full_o         = w_full;
  assign empty_o        = w_empty;
  assign almost_full_o  = (r_elements >= af_thresh_i);
  assign almost_empty_o = (r_elements <= ae_thresh_i);
  assign overflow_o     = r_overflow;

endmodule

// File: tb/tb_io_generic_fifo_pro.sv
// Bench: depth-3 stored FIFO and depth-4 fall-through FIFO, each checked every cycle
// against a queue-level reference model, directed scenarios then random traffic.
module tb_io_generic_fifo_pro;

  logic       clk = 1'b0;
  logic       rstn;
  logic       clr   [2];
  logic       valid [2];
  logic       ready [2];
  logic [7:0] din   [2];
  logic [7:0] dout  [2];
  logic [2:0] af    [2];
  logic [2:0] ae    [2];
  logic [2:0] elems [2];
  logic [2:0] freeo [2];
  logic       rdy_o [2];
  logic       vld_o [2];
  logic       full  [2];
  logic       empty [2];
  logic       afl   [2];
  logic       ael   [2];
  logic       ovf   [2];

  int n_vec = 0;
  int n_err = 0;

  int         m_cnt [2];
  logic [7:0] m_q   [2][8];
  bit         m_ovf [2];

  always #5 clk = ~clk;

  io_generic_fifo_pro #(.DATA_WIDTH(8), .BUFFER_DEPTH(3), .FALL_THROUGH(1'b0)) u_d3 (
    .clk_i(clk), .rstn_i(rstn), .clr_i(clr[0]), .af_thresh_i(af[0]), .ae_thresh_i(ae[0]),
    .valid_i(valid[0]), .data_i(din[0]), .ready_o(rdy_o[0]), .data_o(dout[0]),
    .valid_o(vld_o[0]), .ready_i(ready[0]), .elements_o(elems[0]), .free_o(freeo[0]),
    .full_o(full[0]), .empty_o(empty[0]), .almost_full_o(afl[0]),
    .almost_empty_o(ael[0]), .overflow_o(ovf[0]));

  io_generic_fifo_pro #(.DATA_WIDTH(8), .BUFFER_DEPTH(4), .FALL_THROUGH(1'b1)) u_d4 (
    .clk_i(clk), .rstn_i(rstn), .clr_i(clr[1]), .af_thresh_i(af[1]), .ae_thresh_i(ae[1]),
    .valid_i(valid[1]), .data_i(din[1]), .ready_o(rdy_o[1]), .data_o(dout[1]),
    .valid_o(vld_o[1]), .ready_i(ready[1]), .elements_o(elems[1]), .free_o(freeo[1]),
    .full_o(full[1]), .empty_o(empty[1]), .almost_full_o(afl[1]),
    .almost_empty_o(ael[1]), .overflow_o(ovf[1]));

  function automatic int depth_of(int k);
    return (k == 0) ? 3 : 4;
  endfunction

  function automatic bit ft_of(int k);
    return (k == 1);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(int k);
    int  d;
    bit  e;
    bit  exp_v;
    d     = depth_of(k);
    e     = (m_cnt[k] == 0);
    exp_v = ft_of(k) ? (!e || valid[k]) : !e;
    chk($sformatf("i%0d.ready", k), 32'(rdy_o[k]), 32'(m_cnt[k] != d));
    chk($sformatf("i%0d.valid", k), 32'(vld_o[k]), 32'(exp_v));
    if (exp_v)
      chk($sformatf("i%0d.data", k), 32'(dout[k]), 32'(e ? din[k] : m_q[k][0]));
    chk($sformatf("i%0d.elements", k), 32'(elems[k]), 32'(m_cnt[k]));
    chk($sformatf("i%0d.free", k), 32'(freeo[k]), 32'(d - m_cnt[k]));
    chk($sformatf("i%0d.full", k), 32'(full[k]), 32'(m_cnt[k] == d));
    chk($sformatf("i%0d.empty", k), 32'(empty[k]), 32'(e));
    chk($sformatf("i%0d.almost_full", k), 32'(afl[k]), 32'(m_cnt[k] >= int'(af[k])));
    chk($sformatf("i%0d.almost_empty", k), 32'(ael[k]), 32'(m_cnt[k] <= int'(ae[k])));
    chk($sformatf("i%0d.overflow", k), 32'(ovf[k]), 32'(m_ovf[k]));
  endtask

  // Reference model: queue with front at index 0, applied at each rising edge.
  task automatic model_edge(int k);
    int d;
    bit e, f, byp, pop, push;
    d = depth_of(k);
    if (clr[k]) begin
      m_cnt[k] = 0;
      m_ovf[k] = 1'b0;
      return;
    end
    e    = (m_cnt[k] == 0);
    f    = (m_cnt[k] == d);
    byp  = ft_of(k) && e && valid[k] && ready[k];
    pop  = !e && ready[k];
    push = valid[k] && !f && !byp;
    if (valid[k] && f) m_ovf[k] = 1'b1;
    if (pop) begin
      for (int i = 0; i < 7; i++) m_q[k][i] = m_q[k][i+1];
      m_cnt[k]--;
    end
    if (push) begin
      m_q[k][m_cnt[k]] = din[k];
      m_cnt[k]++;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all(0);
    check_all(1);
    @(posedge clk);
    if (rstn) begin
      model_edge(0);
      model_edge(1);
    end
    #1;
  endtask

  task automatic drive(int k, bit v, logic [7:0] d, bit r, bit c);
    valid[k] = v;
    din[k]   = d;
    ready[k] = r;
    clr[k]   = c;
  endtask

  initial begin
    rstn = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      drive(k, 1'b0, 8'h00, 1'b0, 1'b0);
      af[k] = 3'd3;
      ae[k] = 3'd1;
    end
    #2;
    check_all(0);
    check_all(1);
    chk("rst.data_stored", 32'(dout[0]), 32'h0);
    drive(1, 1'b1, 8'h3C, 1'b0, 1'b0);
    #1;
    check_all(1);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
    #5 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Fill depth-3 to full; fall-through bypass then store on the other side
    drive(0, 1'b1, 8'hA1, 1'b0, 1'b0); drive(1, 1'b1, 8'h55, 1'b1, 1'b0); step();
    drive(0, 1'b1, 8'hA2, 1'b0, 1'b0); drive(1, 1'b1, 8'h55, 1'b0, 1'b0); step();
    drive(0, 1'b1, 8'hA3, 1'b0, 1'b0); drive(1, 1'b0, 8'h00, 1'b0, 1'b0); step();
    drive(0, 1'b1, 8'hA4, 1'b0, 1'b0); drive(1, 1'b1, 8'h61, 1'b0, 1'b0); step();
    drive(0, 1'b0, 8'h00, 1'b1, 1'b0); drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
    af[1] = 3'd2;
    step();
    drive(1, 1'b1, 8'h62, 1'b0, 1'b0); step();
    drive(1, 1'b1, 8'h63, 1'b0, 1'b0); step();
    drive(1, 1'b1, 8'h64, 1'b0, 1'b0); step();
    drive(1, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step();

    // Steady streaming through depth-3 with one word prefilled
    drive(0, 1'b1, 8'h10, 1'b0, 1'b0); step();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'b1, 8'(8'h11 + i), 1'b1, 1'b0);
      step();
    end
    drive(0, 1'b0, 8'h00, 1'b1, 1'b0); step(); step();

    // Clear at two entries with overflow set, handshakes in the clear cycle
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      step();
    end
    drive(0, 1'b0, 8'h00, 1'b1, 1'b0); step();
    drive(0, 1'b1, 8'h99, 1'b1, 1'b1); drive(1, 1'b1, 8'h98, 1'b1, 1'b1); step();
    drive(0, 1'b1, 8'h77, 1'b0, 1'b0); drive(1, 1'b0, 8'h00, 1'b0, 1'b0); step();
    drive(0, 1'b0, 8'h00, 1'b1, 1'b0); step(); step();

    // Asynchronous reset at three entries
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
      drive(1, 1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
      step();
    end
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    check_all(0);
    check_all(1);
    chk("rst_mid.data_stored", 32'(dout[0]), 32'h0);
    @(posedge clk);
    #2 rstn = 1'b1;
    drive(0, 1'b1, 8'hB1, 1'b0, 1'b0); step();
    drive(0, 1'b0, 8'h00, 1'b1, 1'b0); step(); step();

    // Random traffic with random thresholds and occasional clears
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 2; k++) begin
        valid[k] = ($urandom_range(0, 3) != 0);
        din[k]   = 8'($urandom);
        ready[k] = (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
        clr[k]   = ($urandom_range(0, 39) == 0);
        af[k]    = 3'($urandom_range(0, 7));
        ae[k]    = 3'($urandom_range(0, 7));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
